// File: rtl/cp0_regfile_if.sv
// cp0_regfile_if: MFC0 read port, MTC0/exception/ERET commit port and CP0 status outputs
interface cp0_regfile_if #(parameter int HW_INT_W = 6);
  logic [4:0]          read_addr;
  logic [31:0]         read_data;
  logic                write_en;
  logic [4:0]          write_addr;
  logic [31:0]         write_data;
  logic                exc_valid;
  logic [4:0]          exc_code;
  logic [31:0]         exc_pc;
  logic                exc_delay_slot;
  logic [31:0]         exc_badvaddr;
  logic                eret;
  logic [HW_INT_W-1:0] hw_int;
  logic [31:0]         status;
  logic [31:0]         cause;
  logic [31:0]         epc;
  logic                int_req;
  modport master (
    output read_addr, write_en, write_addr, write_data, exc_valid, exc_code, exc_pc,
           exc_delay_slot, exc_badvaddr, eret, hw_int,
    input  read_data, status, cause, epc, int_req
  );
  modport slave (
    input  read_addr, write_en, write_addr, write_data, exc_valid, exc_code, exc_pc,
           exc_delay_slot, exc_badvaddr, eret, hw_int,
    output read_data, status, cause, epc, int_req
  );
endinterface

// File: rtl/cp0_regfile.sv
// cp0_regfile: CP0 Status/Cause/EPC/BadVAddr register file; define CP0_TIMER_EN to add Count/Compare timer
module cp0_regfile #(
  parameter logic [31:0] RESET_STATUS = 32'h0040_0000,
  parameter int          HW_INT_W     = 6
) (
  input logic         clk,
  input logic         rst,
  cp0_regfile_if.slave bus
);
  logic [7:0]          im;
  logic                exl, ie, bd, ti;
  logic [4:0]          code;
  logic [1:0]          ip_sw;
  logic [HW_INT_W-1:0] ip_hw;
  logic [7:0]          ip;
  logic [31:0]         epc_q, bva, count, compare;
  logic                wr;
  // MTC0 only lands when no exception or ERET commits in the same cycle
  assign wr = bus.write_en & ~bus.exc_valid & ~bus.eret;
  assign ip = {ip_hw[HW_INT_W-1] | ti, ip_hw[HW_INT_W-2:0], ip_sw};
  // Status, Cause, EPC and BadVAddr updates by priority: exception, ERET, MTC0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im    <= RESET_STATUS[15:8];
      exl   <= RESET_STATUS[1];
      ie    <= RESET_STATUS[0];
      bd    <= 1'b0;
      code  <= '0;
      ip_sw <= '0;
      ip_hw <= '0;
      epc_q <= '0;
      bva   <= '0;
    end else begin
      ip_hw <= bus.hw_int;
      if (bus.exc_valid) begin
        exl  <= 1'b1;
        code <= bus.exc_code;
        if (!exl) begin
          epc_q <= bus.exc_delay_slot ? bus.exc_pc - 32'd4 : bus.exc_pc;
          bd    <= bus.exc_delay_slot;
        end
        if (bus.exc_code == 5'd4 || bus.exc_code == 5'd5) bva <= bus.exc_badvaddr;
      end else if (bus.eret) begin
        exl <= 1'b0;
      end else if (wr) begin
        if (bus.write_addr == 5'd12) begin
          im  <= bus.write_data[15:8];
          exl <= bus.write_data[1];
          ie  <= bus.write_data[0];
        end
        if (bus.write_addr == 5'd13) ip_sw <= bus.write_data[9:8];
        if (bus.write_addr == 5'd14) epc_q <= bus.write_data;
      end
    end
  end
`ifdef CP0_TIMER_EN
  logic toggle, wr_count, wr_cmp;
  assign wr_count = wr && bus.write_addr == 5'd9;
  assign wr_cmp   = wr && bus.write_addr == 5'd11;
  // Count ticks at half clock rate; TI latches on a tick while Count equals Compare
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle  <= 1'b0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      toggle  <= wr_count ? 1'b0 : ~toggle;
      count   <= wr_count ? bus.write_data : count + {31'b0, toggle};
      compare <= wr_cmp ? bus.write_data : compare;
      ti      <= wr_cmp ? 1'b0 : ti | (toggle & ~wr_count & (count == compare));
    end
  end
`else
  assign count   = '0;
  assign compare = '0;
  assign ti      = 1'b0;
`endif
  assign bus.status  = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
  assign bus.cause   = {bd, ti, 14'b0, ip, 1'b0, code, 2'b0};
  assign bus.epc     = epc_q;
  assign bus.int_req = ie & ~exl & |(ip & im);
  // MFC0 read straight from the registers, no bypass of a same-cycle MTC0
  always_comb begin
    bus.read_data = bus.read_addr == 5'd8  ? bva :
                    bus.read_addr == 5'd9  ? count :
                    bus.read_addr == 5'd11 ? compare :
                    bus.read_addr == 5'd12 ? bus.status :
                    bus.read_addr == 5'd13 ? bus.cause :
                    bus.read_addr == 5'd14 ? epc_q : 32'h0;
  end
endmodule
